// File: rtl/mdio_controller.sv
// Clause-22 MDIO management master: serializes a latched 32-bit frame on MDC/MDIO
// and captures 16 read bits. Define MDIO_PREAMBLE_EN to prepend a 32-bit all-ones preamble.
module mdio_controller #(
    parameter int MDC_HALF = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdio_start,
    input  logic [31:0] t_data,
    input  logic        mdio_in,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [15:0] rd_data,
    output logic        data_rdy,
    output logic        mdio_done,
    output logic        busy,
    output logic        op_err
);

`ifdef MDIO_PREAMBLE_EN
    localparam logic [6:0] PRE_BITS = 7'd32;
`else
    localparam logic [6:0] PRE_BITS = 7'd0;
`endif
    localparam logic [6:0] FRAME_BITS = PRE_BITS + 7'd32;
    localparam logic [7:0] HALF_LAST  = 8'(MDC_HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef MDIO_PREAMBLE_EN
        PREAMBLE,
`endif
        HEADER,
        TURNAROUND,
        WR_DATA,
        RD_DATA,
        DONE
    } state_t;

`ifdef MDIO_PREAMBLE_EN
    localparam state_t FIRST_STATE = PREAMBLE;
`else
    localparam state_t FIRST_STATE = HEADER;
`endif

    state_t      state;
    state_t      launch_state;
    logic [31:0] tx_shift;
    logic [15:0] rx_shift;
    logic [6:0]  bit_cnt;
    logic [6:0]  frame_idx;
    logic [7:0]  half_cnt;
    logic        high_phase;
    logic        is_read;
    logic        launch_oe;
    logic        launch_out;
    logic        launch_pre;
    logic        start_ok;

    assign frame_idx = bit_cnt - PRE_BITS;
    assign start_ok  = mdio_start && (t_data[29:28] == 2'b01 || t_data[29:28] == 2'b10);

    // Phase and drive values for the bit that the next low phase will launch.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        launch_state = HEADER;
        launch_oe    = 1'b1;
        launch_out   = tx_shift[31];
        launch_pre   = 1'b0;
        if (frame_idx >= 7'd16) begin
            launch_state = is_read ? RD_DATA : WR_DATA;
        end else if (frame_idx >= 7'd14) begin
            launch_state = TURNAROUND;
        end
        if (is_read && (launch_state == TURNAROUND || launch_state == RD_DATA)) begin
            launch_oe  = 1'b0;
            launch_out = 1'b0;
        end
`ifdef MDIO_PREAMBLE_EN
        if (bit_cnt < PRE_BITS) begin
            launch_state = PREAMBLE;
            launch_oe    = 1'b1;
            launch_out   = 1'b1;
            launch_pre   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            half_cnt   <= '0;
            high_phase <= 1'b0;
            is_read    <= 1'b0;
            mdc        <= 1'b0;
            mdio_out   <= 1'b0;
            mdio_oe    <= 1'b0;
            rd_data    <= '0;
            data_rdy   <= 1'b0;
            mdio_done  <= 1'b0;
            busy       <= 1'b0;
            op_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge register values.
            mdio_done <= 1'b0;
            data_rdy  <= 1'b0;
            op_err    <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state    <= IDLE;
                    mdc      <= 1'b0;
                    mdio_oe  <= 1'b0;
                    mdio_out <= 1'b0;
                    busy     <= 1'b0;
                    if (start_ok) begin
                        // Acceptance ends a virtual high phase, so the next edge launches bit 0.
                        state      <= FIRST_STATE;
                        tx_shift   <= t_data;
                        is_read    <= (t_data[29:28] == 2'b10);
                        bit_cnt    <= '0;
                        half_cnt   <= HALF_LAST;
                        high_phase <= 1'b1;
                        busy       <= 1'b1;
                    end else if (mdio_start) begin
                        op_err <= 1'b1;
                    end
                end
                default: begin
                    if (half_cnt != HALF_LAST) begin
                        half_cnt <= half_cnt + 8'd1;
                    end else begin
                        half_cnt <= '0;
                        if (!high_phase) begin
                            high_phase <= 1'b1;
                            mdc        <= 1'b1;
                            if (state == RD_DATA) rx_shift <= {rx_shift[14:0], mdio_in};
                        end else if (bit_cnt == FRAME_BITS) begin
                            state     <= DONE;
                            mdc       <= 1'b0;
                            mdio_oe   <= 1'b0;
                            mdio_out  <= 1'b0;
                            busy      <= 1'b0;
                            mdio_done <= 1'b1;
                            if (is_read) begin
                                rd_data  <= rx_shift;
                                data_rdy <= 1'b1;
                            end
                        end else begin
                            state      <= launch_state;
                            high_phase <= 1'b0;
                            mdc        <= 1'b0;
                            mdio_oe    <= launch_oe;
                            mdio_out   <= launch_out;
                            bit_cnt    <= bit_cnt + 7'd1;
                            if (!launch_pre) tx_shift <= {tx_shift[30:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_controller.sv
// Bench for mdio_controller: directed frames with literal expectations plus randomized
// traffic compared every cycle against a timeline model (bit index/phase from edge count).
module tb_mdio_controller;

`ifdef MDIO_PREAMBLE_EN
    localparam int          H              = 2;
    localparam int          PRE            = 32;
    localparam int          EXP_DONE_EDGE  = 257;
    localparam int          EXP_RD_OE_BITS = 46;
    localparam logic [63:0] EXP_WR_SERIAL  = {32'hFFFF_FFFF, 32'h50C2_ABCD};
`else
    localparam int          H              = 1;
    localparam int          PRE            = 0;
    localparam int          EXP_DONE_EDGE  = 65;
    localparam int          EXP_RD_OE_BITS = 14;
    localparam logic [63:0] EXP_WR_SERIAL  = {32'h0000_0000, 32'h50C2_ABCD};
`endif
    localparam int B      = PRE + 32;
    localparam int DONE_K = 2 * H * B + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mdio_start;
    logic [31:0] t_data;
    logic        mdio_in;
    logic        mdc, mdio_out, mdio_oe, data_rdy, mdio_done, busy, op_err;
    logic [15:0] rd_data;

    mdio_controller #(.MDC_HALF(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mdio_start(mdio_start),
        .t_data    (t_data),
        .mdio_in   (mdio_in),
        .mdc       (mdc),
        .mdio_out  (mdio_out),
        .mdio_oe   (mdio_oe),
        .rd_data   (rd_data),
        .data_rdy  (data_rdy),
        .mdio_done (mdio_done),
        .busy      (busy),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int errors   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_k counts edges since acceptance (-1 when idle); everything else is derived from it.
    int          m_k = -1;
    logic [31:0] m_frame = '0;
    bit          m_rd = 1'b0;
    logic [15:0] m_word = '0;
    logic [15:0] m_rd_data = '0;
    bit          m_op_err = 1'b0;
    logic [15:0] next_rd_word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = -1;
            m_rd_data = '0;
            m_op_err = 1'b0;
        end else begin
            m_op_err = 1'b0;
            if (m_k < 0 || m_k == DONE_K) begin
                m_k = -1;
                if (mdio_start) begin
                    if (t_data[29:28] == 2'b01 || t_data[29:28] == 2'b10) begin
                        m_k     = 0;
                        m_frame = t_data;
                        m_rd    = (t_data[29:28] == 2'b10);
                        m_word  = next_rd_word;
                    end else begin
                        m_op_err = 1'b1;
                    end
                end
            end else begin
                m_k++;
            end
            if (m_k == DONE_K && m_rd) m_rd_data = m_word;
        end
    end

    function automatic logic [22:0] exp_vec();
        logic e_mdc, e_out, e_oe;
        int   p, i, j;
        e_mdc = 1'b0;
        e_out = 1'b0;
        e_oe  = 1'b0;
        if (m_k >= 1 && m_k <= 2 * H * B) begin
            p     = m_k - 1;
            i     = p / (2 * H);
            e_mdc = (p % (2 * H)) >= H;
            if (i < PRE) begin
                e_oe  = 1'b1;
                e_out = 1'b1;
            end else begin
                j     = i - PRE;
                e_oe  = !m_rd || (j < 14);
                e_out = e_oe && m_frame[31 - j];
            end
        end
        return {e_mdc, e_out, e_oe, (m_k >= 0 && m_k < DONE_K), (m_k == DONE_K),
                (m_k == DONE_K) && m_rd, m_op_err, m_rd_data};
    endfunction

    // PHY side: the correct read bit is present only for the edge on which MDC rises.
    always @(negedge clk) begin
        int p, i;
        mdio_in = 1'($urandom);
        if (m_k >= 0 && m_k < DONE_K) begin
            p = m_k;
            i = p / (2 * H);
            if ((p % (2 * H)) == H && i >= PRE + 16) mdio_in = m_word[15 - (i - PRE - 16)];
        end
    end

    always @(negedge clk) begin
        if (cmp_en)
            check("outputs", 64'({mdc, mdio_out, mdio_oe, busy, mdio_done, data_rdy, op_err, rd_data}),
                  64'(exp_vec()));
    end

    task automatic wait_done(input int poke_at, output int edges, output logic [63:0] cap,
                             output int oe_bits, output logic rdy);
        logic prev_mdc;
        edges    = -1;
        cap      = '0;
        oe_bits  = 0;
        rdy      = 1'b0;
        prev_mdc = mdc;
        for (int n = 1; n <= 4 * DONE_K; n++) begin
            @(posedge clk);
            #1;
            if (n == poke_at) begin
                mdio_start = 1'b1;
                t_data     = 32'h6AAA_5555;
            end else if (n == poke_at + 1) begin
                mdio_start = 1'b0;
                t_data     = 32'h0;
            end
            if (mdc && !prev_mdc) begin
                cap = {cap[62:0], mdio_out};
                if (mdio_oe) oe_bits++;
            end
            prev_mdc = mdc;
            if (mdio_done) begin
                edges = n;
                rdy   = data_rdy;
                return;
            end
        end
    endtask

    int          edges, oe_bits, cnt, highs;
    logic [63:0] cap;
    logic        rdy;
    int          r;

    initial begin
        rst_n        = 1'b0;
        mdio_start   = 1'b0;
        t_data       = '0;
        next_rd_word = '0;
        repeat (2) @(posedge clk);
        #1 cmp_en = 1'b1;
        @(negedge clk);
        check("reset_state", 64'({mdc, mdio_out, mdio_oe, busy, mdio_done, data_rdy, op_err, rd_data}), 64'h0);
        rst_n = 1'b1;

        // Write, with an ignored start request and T_DATA change mid-frame.
        @(negedge clk);
        t_data     = 32'h50C2_ABCD;
        mdio_start = 1'b1;
        @(posedge clk);
        #1 mdio_start = 1'b0;
        check("wr_busy_rise", 64'(busy), 64'h1);
        wait_done(10, edges, cap, oe_bits, rdy);
        check("wr_done_edge", 64'(edges), 64'(EXP_DONE_EDGE));
        check("wr_serial", cap, EXP_WR_SERIAL);
        check("wr_oe_bits", 64'(oe_bits), 64'(B));
        check("wr_no_data_rdy", 64'(rdy), 64'h0);
        check("wr_keeps_rd_data", 64'(rd_data), 64'h0);

        // Back-to-back read accepted in the DONE cycle.
        t_data       = 32'h60C0_0000;
        next_rd_word = 16'h1234;
        mdio_start   = 1'b1;
        @(posedge clk);
        #1 mdio_start = 1'b0;
        check("b2b_busy_rise", 64'(busy), 64'h1);
        wait_done(-10, edges, cap, oe_bits, rdy);
        check("rd_done_edge", 64'(edges), 64'(EXP_DONE_EDGE));
        check("rd_data_value", 64'(rd_data), 64'h1234);
        check("rd_rdy_with_done", 64'(rdy), 64'h1);
        check("rd_oe_bits", 64'(oe_bits), 64'(EXP_RD_OE_BITS));

        // Illegal OP.
        @(negedge clk);
        t_data     = 32'h40C0_0000;
        mdio_start = 1'b1;
        @(posedge clk);
        #1 mdio_start = 1'b0;
        check("illegal_op_err", 64'(op_err), 64'h1);
        check("illegal_busy", 64'(busy), 64'h0);
        check("illegal_oe", 64'(mdio_oe), 64'h0);
        cnt   = 0;
        highs = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (op_err) cnt++;
            if (mdc) highs++;
        end
        check("illegal_single_pulse", 64'(cnt), 64'h0);
        check("illegal_no_mdc", 64'(highs), 64'h0);

        // Reset at frame bit 20 of a read.
        @(negedge clk);
        t_data       = 32'h60C4_0000;
        next_rd_word = 16'hBEEF;
        mdio_start   = 1'b1;
        @(posedge clk);
        #1 mdio_start = 1'b0;
        repeat (1 + 2 * H * (PRE + 20)) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs", 64'({mdc, mdio_out, mdio_oe, busy, mdio_done, data_rdy, op_err, rd_data}), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt   = 0;
        repeat (DONE_K + 5) begin
            @(negedge clk);
            if (mdio_done || data_rdy) cnt++;
        end
        check("abort_no_done", 64'(cnt), 64'h0);
        check("abort_rd_data", 64'(rd_data), 64'h0);

        // Randomized traffic, biased to start again during the DONE cycle.
        for (int c = 0; c < 12 * DONE_K; c++) begin
            @(negedge clk);
            next_rd_word = 16'($urandom);
            t_data       = $urandom;
            r            = int'($urandom_range(0, 7));
            t_data[29:28] = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 5) ? 2'b01 : 2'b10;
            mdio_start   = mdio_done ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
        end
        mdio_start = 1'b0;
        repeat (DONE_K + 4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
